// File: rtl/mib_slave_cmd_bridge.sv
// MIB slave endpoint: decodes muxed 16-bit MIB address/data phases and re-issues
// each accepted transaction as one 24-bit-address, 32-bit-data cmd-bus access.
module mib_slave_cmd_bridge #(
  parameter logic [3:0]  P_MIB_MSN              = 4'h0,
  parameter int unsigned P_CMD_ACK_TIMEOUT_CLKS = 16
) (
  input  logic        i_sysclk,
  input  logic        i_srst_n,
  input  logic        i_mib_start,
  input  logic        i_mib_rd_wr_n,
  input  logic [15:0] i_mib_ad,
  output logic [15:0] o_mib_ad,
  output logic        o_mib_ad_high_z,
  output logic        o_mib_slave_ack,
  output logic        o_cmd_sel,
  output logic        o_cmd_rd_wr_n,
  output logic [23:0] o_cmd_byte_addr,
  output logic [31:0] o_cmd_wdata,
  input  logic [31:0] i_cmd_rdata,
  input  logic        i_cmd_ack,
  output logic        o_cmd_timeout
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR2,
    S_WDATA1,
    S_WDATA2,
    S_CMD_ISSUE,
    S_CMD_WAIT,
    S_WR_ACK,
    S_RD_D1,
    S_RD_D2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(P_CMD_ACK_TIMEOUT_CLKS - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        rd_wr_n_p0;
  logic [7:0]  addr_hi_p0;
  logic [15:0] addr_lo_p1;
  logic [15:0] wdata_hi_p2;
  logic [31:0] rdata_p3;

  function automatic logic msn_match(input logic [7:0] addr_hi);
    return addr_hi[7:4] == P_MIB_MSN;
  endfunction

  // Phase captures: address phase 1, address phase 2, write-data phase 1, cmd read data
  always_ff @(posedge i_sysclk) begin
    if (state == S_IDLE && i_mib_start) begin
      addr_hi_p0 <= i_mib_ad[7:0];
      rd_wr_n_p0 <= i_mib_rd_wr_n;
    end
    if (state == S_ADDR2) addr_lo_p1 <= i_mib_ad;
    if (state == S_WDATA1) wdata_hi_p2 <= i_mib_ad;
    if (state == S_CMD_WAIT && i_cmd_ack) rdata_p3 <= i_cmd_rdata;
  end

  always_ff @(posedge i_sysclk) begin
    if (!i_srst_n) begin
      state           <= S_IDLE;
      wait_cnt        <= 8'd0;
      o_mib_ad        <= 16'h0000;
      o_mib_ad_high_z <= 1'b1;
      o_mib_slave_ack <= 1'b0;
      o_cmd_sel       <= 1'b0;
      o_cmd_rd_wr_n   <= 1'b1;
      o_cmd_byte_addr <= 24'h000000;
      o_cmd_wdata     <= 32'h00000000;
      o_cmd_timeout   <= 1'b0;
    end else begin
      // Strobes and the MIB drive default to idle; states below override for one cycle.
      o_cmd_sel       <= 1'b0;
      o_cmd_timeout   <= 1'b0;
      o_mib_slave_ack <= 1'b0;
      o_mib_ad_high_z <= 1'b1;
      o_mib_ad        <= 16'h0000;

      case (state)
        S_IDLE: begin
          if (i_mib_start) state <= S_ADDR2;
        end

        S_ADDR2: begin
          if (!msn_match(addr_hi_p0)) begin
            state <= S_IDLE;
          end else if (rd_wr_n_p0) begin
            state           <= S_CMD_ISSUE;
            o_cmd_sel       <= 1'b1;
            o_cmd_rd_wr_n   <= 1'b1;
            o_cmd_byte_addr <= {addr_hi_p0, i_mib_ad};
          end else begin
            state <= S_WDATA1;
          end
        end

        S_WDATA1: state <= S_WDATA2;

        S_WDATA2: begin
          state           <= S_CMD_ISSUE;
          o_cmd_sel       <= 1'b1;
          o_cmd_rd_wr_n   <= 1'b0;
          o_cmd_byte_addr <= {addr_hi_p0, addr_lo_p1};
          o_cmd_wdata     <= {wdata_hi_p2, i_mib_ad};
        end

        S_CMD_ISSUE: begin
          wait_cnt <= 8'd0;
          state    <= S_CMD_WAIT;
        end

        // An ack on the last counted cycle is checked first, so it beats the timeout.
        S_CMD_WAIT: begin
          if (i_cmd_ack) begin
            if (rd_wr_n_p0) begin
              state <= S_RD_D1;
            end else begin
              state           <= S_WR_ACK;
              o_mib_slave_ack <= 1'b1;
            end
          end else if (wait_cnt == TMO_LAST) begin
            o_cmd_timeout <= 1'b1;
            state         <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        S_WR_ACK: state <= S_IDLE;

        // Read data is registered out of the latched rdata, so pins lag the state by one cycle.
        S_RD_D1: begin
          o_mib_ad        <= rdata_p3[31:16];
          o_mib_ad_high_z <= 1'b0;
          o_mib_slave_ack <= 1'b1;
          state           <= S_RD_D2;
        end

        S_RD_D2: begin
          o_mib_ad        <= rdata_p3[15:0];
          o_mib_ad_high_z <= 1'b0;
          o_mib_slave_ack <= 1'b1;
          state           <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mib_slave_cmd_bridge.sv
// Randomized self-checking bench for mib_slave_cmd_bridge with an event-timing
// reference model derived from the transaction latencies and timeout rules.
module tb_mib_slave_cmd_bridge;

  localparam logic [3:0] MSN = 4'h0;
  localparam int         TMO = 16;

  logic        i_sysclk = 1'b0;
  logic        i_srst_n = 1'b0;
  logic        i_mib_start = 1'b0;
  logic        i_mib_rd_wr_n = 1'b0;
  logic [15:0] i_mib_ad = 16'h0;
  logic [15:0] o_mib_ad;
  logic        o_mib_ad_high_z;
  logic        o_mib_slave_ack;
  logic        o_cmd_sel;
  logic        o_cmd_rd_wr_n;
  logic [23:0] o_cmd_byte_addr;
  logic [31:0] o_cmd_wdata;
  logic [31:0] i_cmd_rdata = 32'h0;
  logic        i_cmd_ack = 1'b0;
  logic        o_cmd_timeout;

  int vectors = 0;
  int miscompares = 0;

  always #5 i_sysclk = ~i_sysclk;

  mib_slave_cmd_bridge #(.P_MIB_MSN(MSN), .P_CMD_ACK_TIMEOUT_CLKS(TMO)) dut (
    .i_sysclk        (i_sysclk),
    .i_srst_n        (i_srst_n),
    .i_mib_start     (i_mib_start),
    .i_mib_rd_wr_n   (i_mib_rd_wr_n),
    .i_mib_ad        (i_mib_ad),
    .o_mib_ad        (o_mib_ad),
    .o_mib_ad_high_z (o_mib_ad_high_z),
    .o_mib_slave_ack (o_mib_slave_ack),
    .o_cmd_sel       (o_cmd_sel),
    .o_cmd_rd_wr_n   (o_cmd_rd_wr_n),
    .o_cmd_byte_addr (o_cmd_byte_addr),
    .o_cmd_wdata     (o_cmd_wdata),
    .i_cmd_rdata     (i_cmd_rdata),
    .i_cmd_ack       (i_cmd_ack),
    .o_cmd_timeout   (o_cmd_timeout)
  );

  task automatic cyc();
    @(negedge i_sysclk);
  endtask

  task automatic idle_inputs();
    i_mib_start   = 1'b0;
    i_mib_rd_wr_n = 1'b0;
    i_mib_ad      = 16'h0;
    i_cmd_ack     = 1'b0;
    i_cmd_rdata   = 32'h0;
  endtask

  // One MIB transaction; the cmd responder acks d cycles after it sees sel.
  // Model: sel at cycle 2 (read) / 4 (write); write ack one cycle after cmd ack;
  // read data 2 and 3 cycles after cmd ack; timeout pulse the cycle after wait cycle TMO.
  task automatic run_txn(input string tag, input logic rd, input logic [23:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdat,
                         input int d, input int inj);
    logic        acc;
    int          s_exp, a, c_end, sel_obs;
    logic        e_sel, e_tmo, e_ack, e_hz;
    logic [15:0] e_ad;
    logic [19:0] got, exp_v;
    acc   = (addr[23:20] == MSN);
    s_exp = rd ? 2 : 4;
    a     = (d <= TMO) ? s_exp + d : -100;
    if (!acc) c_end = 8;
    else if (d > TMO) c_end = s_exp + TMO + 4;
    else c_end = a + 6;
    sel_obs = -1;
    for (int c = 0; c <= c_end; c++) begin
      cyc();
      e_sel = acc && (c == s_exp);
      e_tmo = acc && (d > TMO) && (c == s_exp + TMO + 1);
      e_ack = 1'b0; e_hz = 1'b1; e_ad = 16'h0;
      if (acc && d <= TMO) begin
        if (!rd) e_ack = (c == a + 1);
        else if (c == a + 2) begin e_ack = 1'b1; e_hz = 1'b0; e_ad = rdat[31:16]; end
        else if (c == a + 3) begin e_ack = 1'b1; e_hz = 1'b0; e_ad = rdat[15:0]; end
      end
      got   = {o_cmd_sel, o_cmd_timeout, o_mib_slave_ack, o_mib_ad_high_z, o_mib_ad};
      exp_v = {e_sel, e_tmo, e_ack, e_hz, e_ad};
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL %s cyc%0d sel/tmo/ack/hz/ad got=%h exp=%h", tag, c, got, exp_v);
      end
      if (o_cmd_sel === 1'b1) begin
        sel_obs = c;
        vectors++;
        if (o_cmd_rd_wr_n !== rd || o_cmd_byte_addr !== addr ||
            (!rd && o_cmd_wdata !== wd)) begin
          miscompares++;
          $display("FAIL %s cmd_fields got rw=%b a=%h wd=%h exp rw=%b a=%h wd=%h", tag,
                   o_cmd_rd_wr_n, o_cmd_byte_addr, o_cmd_wdata, rd, addr, wd);
        end
      end
      i_mib_start   = (c == 0) || (c == inj);
      i_mib_rd_wr_n = (c == 0) ? rd : 1'(($urandom));
      case (c)
        0: i_mib_ad = {8'h00, addr[23:16]};
        1: i_mib_ad = addr[15:0];
        2: i_mib_ad = rd ? 16'($urandom) : wd[31:16];
        3: i_mib_ad = rd ? 16'($urandom) : wd[15:0];
        default: i_mib_ad = 16'($urandom);
      endcase
      i_cmd_ack   = (sel_obs >= 0) && (c == sel_obs + d);
      i_cmd_rdata = i_cmd_ack ? rdat : $urandom;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    i_srst_n = 1'b0;
    idle_inputs();
    repeat (3) cyc();
    i_srst_n = 1'b1;
    vectors++;
    if (o_mib_ad !== 16'h0) begin miscompares++; $display("FAIL rst_mib_ad got=%h exp=0", o_mib_ad); end
    vectors++;
    if (o_mib_ad_high_z !== 1'b1) begin miscompares++; $display("FAIL rst_high_z got=%b exp=1", o_mib_ad_high_z); end
    vectors++;
    if (o_mib_slave_ack !== 1'b0) begin miscompares++; $display("FAIL rst_ack got=%b exp=0", o_mib_slave_ack); end
    vectors++;
    if (o_cmd_sel !== 1'b0) begin miscompares++; $display("FAIL rst_sel got=%b exp=0", o_cmd_sel); end
    vectors++;
    if (o_cmd_rd_wr_n !== 1'b1) begin miscompares++; $display("FAIL rst_rd_wr_n got=%b exp=1", o_cmd_rd_wr_n); end
    vectors++;
    if (o_cmd_byte_addr !== 24'h0) begin miscompares++; $display("FAIL rst_addr got=%h exp=0", o_cmd_byte_addr); end
    vectors++;
    if (o_cmd_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_wdata got=%h exp=0", o_cmd_wdata); end
    vectors++;
    if (o_cmd_timeout !== 1'b0) begin miscompares++; $display("FAIL rst_timeout got=%b exp=0", o_cmd_timeout); end
    cyc();
  endtask

  task automatic test_write();
    run_txn("write", 1'b0, 24'h000004, 32'h01010202, 32'h0, 3, -1);
  endtask

  task automatic test_read();
    run_txn("read", 1'b1, 24'h000008, 32'h0, 32'hDEADBEEF, 1, -1);
  endtask

  task automatic test_msn_mismatch();
    run_txn("msn_miss", 1'b1, 24'h100004, 32'h0, 32'h12345678, 1, -1);
    run_txn("msn_miss_wr", 1'b0, 24'hF00010, 32'hCAFEF00D, 32'h0, 1, -1);
    run_txn("after_miss", 1'b1, 24'h000000, 32'h0, $urandom, 2, -1);
  endtask

  task automatic test_timeout();
    run_txn("tmo_never", 1'b1, 24'h000020, 32'h0, 32'h0BADF00D, 1000, -1);
    run_txn("tmo_late", 1'b0, 24'h000024, 32'h11112222, 32'h0, TMO + 1, -1);
    run_txn("ack_last", 1'b1, 24'h000028, 32'h0, 32'h5A5AA5A5, TMO, -1);
    run_txn("wr_after_tmo", 1'b0, 24'h00002C, 32'h33334444, 32'h0, 1, -1);
  endtask

  task automatic test_reset_midtxn();
    logic [79:0] got;
    // Read of 0x0ABCDE; reset lands in the second CMD_WAIT cycle.
    for (int c = 0; c <= 12; c++) begin
      cyc();
      if (c == 2) begin
        vectors++;
        if (o_cmd_sel !== 1'b1) begin miscompares++; $display("FAIL midrst_sel got=%b exp=1", o_cmd_sel); end
      end
      if (c == 5) begin
        got = {o_mib_ad, o_mib_ad_high_z, o_mib_slave_ack, o_cmd_sel, o_cmd_rd_wr_n,
               o_cmd_byte_addr, o_cmd_wdata, o_cmd_timeout};
        vectors++;
        if (got !== {16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0, 32'h0, 1'b0}) begin
          miscompares++;
          $display("FAIL midrst_outputs got=%h exp=%h", got,
                   {16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0, 32'h0, 1'b0});
        end
      end
      if (c >= 7) begin
        vectors++;
        if ({o_mib_slave_ack, o_mib_ad_high_z, o_cmd_sel, o_cmd_timeout, o_mib_ad} !== {4'b0100, 16'h0}) begin
          miscompares++;
          $display("FAIL midrst_quiet cyc%0d got=%h exp=%h", c,
                   {o_mib_slave_ack, o_mib_ad_high_z, o_cmd_sel, o_cmd_timeout, o_mib_ad}, {4'b0100, 16'h0});
        end
      end
      i_mib_start   = (c == 0);
      i_mib_rd_wr_n = 1'b1;
      i_mib_ad      = (c == 0) ? 16'h000A : (c == 1) ? 16'hBCDE : 16'h0;
      i_srst_n      = (c != 4);
      i_cmd_ack     = (c == 6);
      i_cmd_rdata   = 32'hFEEDFACE;
    end
    idle_inputs();
    i_srst_n = 1'b1;
    cyc();
  endtask

  task automatic test_start_inject();
    run_txn("inject_wd1", 1'b0, 24'h000030, 32'hA5A51234, 32'h0, 2, 2);
    run_txn("inject_wait", 1'b1, 24'h000034, 32'h0, 32'h87654321, 4, 5);
  endtask

  task automatic test_back_to_back();
    logic        rd;
    logic [23:0] addr;
    int          d;
    for (int n = 0; n < 40; n++) begin
      rd   = 1'($urandom);
      addr = 24'($urandom);
      addr[23:20] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : MSN;
      d    = $urandom_range(1, 20);
      run_txn($sformatf("rand%0d", n), rd, addr, $urandom, $urandom, d, -1);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_msn_mismatch();
    test_timeout();
    test_reset_midtxn();
    test_write();
    test_start_inject();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mib_slave_cmd_bridge.md
Name: mib_slave_cmd_bridge

Overview:
MIB slave endpoint, directly downstream of mib_master on the shared 16-bit muxed MIB bus. It decodes MIB address, write-data and read-data phases and re-issues each accepted transaction as a single 24-bit-address, 32-bit-data cmd-bus access into the FPGA's local register space. It returns the write ack or the two read-data phases to the master. It sits at the MIB pins of each slave FPGA top (e.g. cs23_top), behind the board-level I/O registers.

Parameters:
P_MIB_MSN, 4'h0, slave select; a transaction is accepted only when byte_addr[23:20] equals this value.
P_CMD_ACK_TIMEOUT_CLKS, 16, CMD_WAIT cycles without i_cmd_ack before abort; valid range 1..255.

Ports:
i_sysclk  in  1  single clock for MIB and cmd sides
i_srst_n  in  1  synchronous reset, active-low
i_mib_start  in  1  high for one clock on address phase 1
i_mib_rd_wr_n  in  1  1 = read, 0 = write; sampled with i_mib_start
i_mib_ad  in  16  master-driven address/write-data phases
o_mib_ad  out  16  slave-driven read data
o_mib_ad_high_z  out  1  1 = tri-state MIB AD at top level
o_mib_slave_ack  out  1  write ack / read-data-valid
o_cmd_sel  out  1  one-clock cmd request strobe
o_cmd_rd_wr_n  out  1  cmd direction
o_cmd_byte_addr  out  24  cmd address
o_cmd_wdata  out  32  cmd write data
i_cmd_rdata  in  32  cmd read data, valid with i_cmd_ack
i_cmd_ack  in  1  cmd completion
o_cmd_timeout  out  1  one-clock pulse on cmd ack timeout

Behaviour:
- Reset (i_srst_n=0 at a clock edge): state IDLE, timeout counter 0.
- Output reset values: o_mib_ad=0, o_mib_ad_high_z=1, o_mib_slave_ack=0, o_cmd_sel=0, o_cmd_rd_wr_n=1, o_cmd_byte_addr=0, o_cmd_wdata=0, o_cmd_timeout=0.
- Reset mid-transaction aborts it. No ack is issued. The master recovers by its own timeout.
- All outputs are registered. Every "cycle" below is an i_sysclk edge.
- Phase mapping: address phase 1 carries {8'h00, addr[23:16]}; address phase 2 carries addr[15:0]. Write data phase 1 carries wdata[31:16]; phase 2 carries wdata[15:0]. Read data phases use the same split.
- IDLE: on i_mib_start=1, capture i_mib_ad[7:0] as addr[23:16] and capture i_mib_rd_wr_n; go to ADDR2. i_mib_start is ignored in every other state.
- ADDR2: capture addr[15:0].
  - If addr[23:20] != P_MIB_MSN: go to IDLE with no cmd activity. The following write-data phases carry no start and are ignored.
  - Write: go to WDATA1. Read: go to CMD_ISSUE.
- WDATA1: capture wdata[31:16]. WDATA2: capture wdata[15:0], then go to CMD_ISSUE.
- CMD_ISSUE: drive o_cmd_sel=1 for exactly one cycle, with addr/wdata/rd_wr_n stable. Clear the counter and go to CMD_WAIT. o_cmd_byte_addr, o_cmd_wdata and o_cmd_rd_wr_n hold until the next CMD_ISSUE.
- CMD_WAIT: sample i_cmd_ack starting the cycle after sel; the counter increments each cycle with no ack.
  - On ack: latch i_cmd_rdata. Write goes to WR_ACK; read goes to RD_D1.
  - If the counter reaches P_CMD_ACK_TIMEOUT_CLKS with no ack: pulse o_cmd_timeout for one cycle, return to IDLE, no MIB ack. Ack arriving on the final counted cycle wins over timeout.
  - A late i_cmd_ack seen in IDLE is ignored.
- WR_ACK: o_mib_slave_ack=1 for one cycle, then go to IDLE.
- RD_D1: o_mib_ad_high_z=0, o_mib_ad=rdata[31:16], o_mib_slave_ack=1.
- RD_D2: o_mib_ad=rdata[15:0], ack=1. Next cycle: high_z=1, ack=0, o_mib_ad=0, state IDLE.
- o_mib_ad_high_z is 0 only during exactly the two read-data cycles.
- Best-case latency, measured from the start cycle with zero-wait cmd ack (ack the cycle after sel):
  - Write: ack 6 cycles after start.
  - Read: first data phase 5 cycles after start.

Test Plan:
1. Write: MIB phases 0x0000, 0x0004, 0x0101, 0x0202; cmd ack 3 cycles after sel -> one sel pulse with addr 0x000004, wdata 0x01010202, rd_wr_n=0; single o_mib_slave_ack pulse the cycle after cmd ack.
2. Read of 0x000008 with i_cmd_rdata=0xDEADBEEF -> o_mib_ad 0xDEAD then 0xBEEF on consecutive cycles with ack=1; high_z=0 exactly those 2 cycles.
3. Read of 0x100004 (MSN mismatch, P_MIB_MSN=0) -> no o_cmd_sel, no ack, high_z stays 1; a following valid read to 0x000000 completes normally.
4. i_cmd_ack never asserted -> o_cmd_timeout single pulse on CMD_WAIT cycle 16, no MIB ack. Ack on cycle 16 instead -> normal completion, no timeout. The next write succeeds.
5. i_srst_n=0 for one cycle during CMD_WAIT of a read -> every output at its reset value next cycle; a later cmd ack produces no MIB activity.
6. i_mib_start pulse injected during WDATA1 -> ignored; the original transaction completes with correct wdata.
